// File: rtl/key_sw_conditioner.sv
// key_sw_conditioner: brings board switches and push-buttons into the clk domain,
// debounces each key and emits registered one-cycle press/release pulses.
module key_sw_conditioner #(
  parameter int SW_WIDTH        = 10,
  parameter int KEY_WIDTH       = 2,
  parameter int DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [SW_WIDTH-1:0]  sw_in,
  input  logic [KEY_WIDTH-1:0] key_in,
  output logic [SW_WIDTH-1:0]  sw_sync,
  output logic [KEY_WIDTH-1:0] key_clean,
  output logic [KEY_WIDTH-1:0] key_press,
  output logic [KEY_WIDTH-1:0] key_release
);

  localparam int               CNT_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [SW_WIDTH-1:0]  r_sw_meta;
  logic [SW_WIDTH-1:0]  r_sw_sync;
  logic [KEY_WIDTH-1:0] r_key_meta;
  logic [KEY_WIDTH-1:0] r_key_sync;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sw_meta <= '0;
      r_sw_sync <= '0;
    end else begin
      r_sw_meta <= sw_in;
      r_sw_sync <= r_sw_meta;
    end
  end

  // Key synchronisers idle high so a reset looks like "all keys released".
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_key_meta <= '1;
      r_key_sync <= '1;
    end else begin
      r_key_meta <= key_in;
      r_key_sync <= r_key_meta;
    end
  end

  assign sw_sync = r_sw_sync;

  genvar gi;
  generate
    for (gi = 0; gi < KEY_WIDTH; gi++) begin : g_key
      logic [CNT_W-1:0] r_cnt;
      logic             r_clean;
      logic             r_press;
      logic             r_release;
      logic             w_ks;
      logic             w_differ;

      assign w_ks     = r_key_sync[gi];
      assign w_differ = (w_ks != r_clean);

      // Any return to the accepted level restarts the window from zero.
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          r_cnt     <= '0;
          r_clean   <= 1'b1;
          r_press   <= 1'b0;
          r_release <= 1'b0;
        end else begin
          r_press   <= 1'b0;
          r_release <= 1'b0;
          if (!w_differ) begin
            r_cnt <= '0;
          end else if (r_cnt == CNT_LAST) begin
            r_cnt     <= '0;
            r_clean   <= w_ks;
            r_press   <= ~w_ks;
            r_release <= w_ks;
          end else begin
            r_cnt <= r_cnt + CNT_ONE;
          end
        end
      end

      assign key_clean[gi]   = r_clean;
      assign key_press[gi]   = r_press;
      assign key_release[gi] = r_release;
    end
  endgenerate

endmodule

// File: tb/tb_key_sw_conditioner.sv
// Directed bench for key_sw_conditioner with DEBOUNCE_CYCLES=4: a per-edge vector
// table plus hand-written bounce and mid-count reset sequences.
module tb_key_sw_conditioner;

  localparam int SW_W  = 10;
  localparam int KEY_W = 2;
  localparam int DB    = 4;

  logic             clk;
  logic             rst_n;
  logic [SW_W-1:0]  sw_in;
  logic [KEY_W-1:0] key_in;
  logic [SW_W-1:0]  sw_sync;
  logic [KEY_W-1:0] key_clean;
  logic [KEY_W-1:0] key_press;
  logic [KEY_W-1:0] key_release;

  key_sw_conditioner #(
    .SW_WIDTH       (SW_W),
    .KEY_WIDTH      (KEY_W),
    .DEBOUNCE_CYCLES(DB)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sw_in      (sw_in),
    .key_in     (key_in),
    .sw_sync    (sw_sync),
    .key_clean  (key_clean),
    .key_press  (key_press),
    .key_release(key_release)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [KEY_W-1:0] key;
    logic [SW_W-1:0]  sw;
    logic [KEY_W-1:0] exp_clean;
    logic [KEY_W-1:0] exp_press;
    logic [KEY_W-1:0] exp_rel;
    logic [SW_W-1:0]  exp_sw;
  } vec_t;

  vec_t vecs[$];
  int   n_checks = 0;
  int   n_errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic add(input logic [KEY_W-1:0] k, input logic [SW_W-1:0] s,
                     input logic [KEY_W-1:0] c, input logic [KEY_W-1:0] p,
                     input logic [KEY_W-1:0] r, input logic [SW_W-1:0] ss);
    vec_t v;
    v.key = k; v.sw = s; v.exp_clean = c; v.exp_press = p; v.exp_rel = r; v.exp_sw = ss;
    vecs.push_back(v);
  endtask

  initial begin
    int press_cnt;
    int rel_cnt;

    // Row = inputs applied before an edge, outputs expected just after it.
    add(2'b11, 10'h000, 2'b11, 2'b00, 2'b00, 10'h000);
    // Clean press of key0 together with switch change (edge N).
    add(2'b10, 10'h3FF, 2'b11, 2'b00, 2'b00, 10'h000);
    add(2'b10, 10'h3FF, 2'b11, 2'b00, 2'b00, 10'h3FF);
    add(2'b10, 10'h3FF, 2'b11, 2'b00, 2'b00, 10'h3FF);
    add(2'b10, 10'h3FF, 2'b11, 2'b00, 2'b00, 10'h3FF);
    add(2'b10, 10'h3FF, 2'b11, 2'b00, 2'b00, 10'h3FF);
    add(2'b10, 10'h3FF, 2'b10, 2'b01, 2'b00, 10'h3FF);
    add(2'b10, 10'h3FF, 2'b10, 2'b00, 2'b00, 10'h3FF);
    // Key1 press, switch pattern change (edge M).
    add(2'b00, 10'h155, 2'b10, 2'b00, 2'b00, 10'h3FF);
    add(2'b00, 10'h155, 2'b10, 2'b00, 2'b00, 10'h155);
    add(2'b00, 10'h155, 2'b10, 2'b00, 2'b00, 10'h155);
    add(2'b00, 10'h155, 2'b10, 2'b00, 2'b00, 10'h155);
    add(2'b00, 10'h155, 2'b10, 2'b00, 2'b00, 10'h155);
    add(2'b00, 10'h155, 2'b00, 2'b10, 2'b00, 10'h155);
    add(2'b00, 10'h155, 2'b00, 2'b00, 2'b00, 10'h155);
    // Both keys released on the same edge.
    add(2'b11, 10'h155, 2'b00, 2'b00, 2'b00, 10'h155);
    add(2'b11, 10'h155, 2'b00, 2'b00, 2'b00, 10'h155);
    add(2'b11, 10'h155, 2'b00, 2'b00, 2'b00, 10'h155);
    add(2'b11, 10'h155, 2'b00, 2'b00, 2'b00, 10'h155);
    add(2'b11, 10'h155, 2'b00, 2'b00, 2'b00, 10'h155);
    add(2'b11, 10'h155, 2'b11, 2'b00, 2'b11, 10'h155);
    add(2'b11, 10'h155, 2'b11, 2'b00, 2'b00, 10'h155);

    // Reset held with arbitrary inputs and a running clock.
    rst_n  = 1'b0;
    key_in = 2'b00;
    sw_in  = 10'h3FF;
    repeat (3) tick();
    chk("rst_clean",   32'(key_clean),   32'(2'b11));
    chk("rst_sw",      32'(sw_sync),     32'h0);
    chk("rst_press",   32'(key_press),   32'h0);
    chk("rst_release", 32'(key_release), 32'h0);
    key_in = 2'b11;
    sw_in  = 10'h000;
    rst_n  = 1'b1;

    for (int i = 0; i < vecs.size(); i++) begin
      key_in = vecs[i].key;
      sw_in  = vecs[i].sw;
      tick();
      chk($sformatf("vec%0d_clean", i),   32'(key_clean),   32'(vecs[i].exp_clean));
      chk($sformatf("vec%0d_press", i),   32'(key_press),   32'(vecs[i].exp_press));
      chk($sformatf("vec%0d_release", i), 32'(key_release), 32'(vecs[i].exp_rel));
      chk($sformatf("vec%0d_sw", i),      32'(sw_sync),     32'(vecs[i].exp_sw));
      $display("vec %0d: key_in=%b sw_in=%h -> clean=%b press=%b rel=%b sw_sync=%h",
               i, vecs[i].key, vecs[i].sw, key_clean, key_press, key_release, sw_sync);
    end

    // Bounce: low for edges B0..B2, high for B3, low from B4 on; press only at B9.
    press_cnt = 0;
    for (int b = 0; b < 13; b++) begin
      key_in = (b == 3) ? 2'b11 : 2'b10;
      tick();
      if (key_press != 2'b00) press_cnt++;
      chk($sformatf("bounce_b%0d_press", b), 32'(key_press), (b == 9) ? 32'h1 : 32'h0);
      chk($sformatf("bounce_b%0d_clean", b), 32'(key_clean), (b >= 9) ? 32'h2 : 32'h3);
      $display("bounce edge %0d: key_in=%b clean=%b press=%b", b, key_in, key_clean, key_press);
    end
    chk("bounce_press_count", 32'(press_cnt), 32'h1);

    // Mid-count reset: key0 release and key1 press both pending at count 2.
    key_in = 2'b01;
    repeat (4) tick();
    chk("pre_rst_clean", 32'(key_clean), 32'(2'b10));
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_clean",   32'(key_clean),   32'(2'b11));
    chk("async_rst_sw",      32'(sw_sync),     32'h0);
    chk("async_rst_press",   32'(key_press),   32'h0);
    chk("async_rst_release", 32'(key_release), 32'h0);
    $display("async reset: clean=%b sw_sync=%h press=%b rel=%b", key_clean, sw_sync, key_press, key_release);
    repeat (2) tick();
    rst_n = 1'b1;
    press_cnt = 0;
    rel_cnt   = 0;
    for (int r = 0; r < 8; r++) begin
      tick();
      if (key_press != 2'b00)   press_cnt++;
      if (key_release != 2'b00) rel_cnt++;
      chk($sformatf("post_rst_r%0d_press", r), 32'(key_press), (r == 5) ? 32'h2 : 32'h0);
      chk($sformatf("post_rst_r%0d_clean", r), 32'(key_clean), (r >= 5) ? 32'h1 : 32'h3);
      $display("post-reset edge R+%0d: clean=%b press=%b rel=%b", r, key_clean, key_press, key_release);
    end
    chk("post_rst_press_count",   32'(press_cnt), 32'h1);
    chk("post_rst_release_count", 32'(rel_cnt),   32'h0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
